// File: rtl/clk_div_pkg.sv
// Shared defaults and width helper for the multi-channel clock divider.
package clk_div_pkg;

  localparam int CNT_W_DEF        = 16;
  localparam int DEFAULT_HALF_DEF = 4999;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Divisor write port: Div_Wr/Div_Sel/Div_Data offered by master, Div_Rdy returned by slave.
interface clk_div_multi_if import clk_div_pkg::*; #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = CNT_W_DEF
);
  localparam int SEL_W = sel_w(CHANNELS);

  logic             Div_Wr;
  logic [SEL_W-1:0] Div_Sel;
  logic [CNT_W-1:0] Div_Data;
  logic             Div_Rdy;

  modport master (output Div_Wr, Div_Sel, Div_Data, input Div_Rdy);
  modport slave  (input Div_Wr, Div_Sel, Div_Data, output Div_Rdy);

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: Tick every H+1 cycles, Clk_Div toggles on each Tick; outputs registered.
// A written divisor waits in pending until the next terminal count (or next disabled edge).
module clk_div_chan import clk_div_pkg::*; #(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int DEFAULT_HALF = DEFAULT_HALF_DEF
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             enable,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync,
`endif
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_data,
  output logic             pend,
  output logic             tick,
  output logic             clk_div
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] pend_half;
  logic             sync_hit;

`ifdef CLKDIV_SYNC_EN
  assign sync_hit = sync;
`else
  assign sync_hit = 1'b0;
`endif

  // wr_en is only raised while pend is clear, so a write and an apply never share an edge.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt       <= '0;
      half      <= CNT_W'(DEFAULT_HALF);
      pend_half <= '0;
      pend      <= 1'b0;
      tick      <= 1'b0;
      clk_div   <= 1'b0;
    end else begin
      if (wr_en) begin
        pend_half <= wr_data;
        pend      <= 1'b1;
      end
      if (sync_hit) begin
        cnt     <= '0;
        tick    <= 1'b0;
        clk_div <= 1'b0;
      end else if (!enable) begin
        cnt     <= '0;
        tick    <= 1'b0;
        clk_div <= 1'b0;
        if (pend) begin
          half <= pend_half;
          pend <= 1'b0;
        end
      end else if (cnt == half) begin
        cnt     <= '0;
        tick    <= 1'b1;
        clk_div <= ~clk_div;
        if (pend) begin
          half <= pend_half;
          pend <= 1'b0;
        end
      end else begin
        cnt  <= cnt + CNT_W'(1);
        tick <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// CHANNELS independent programmable dividers sharing one divisor write port; Div_Rdy is combinational
// (low while the selected channel holds a pending divisor). Sync port exists only with CLKDIV_SYNC_EN.
module clk_div_multi import clk_div_pkg::*; #(
  parameter int CHANNELS     = 4,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int DEFAULT_HALF = DEFAULT_HALF_DEF
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic [CHANNELS-1:0] Enable,
  clk_div_multi_if.slave      div_if,
`ifdef CLKDIV_SYNC_EN
  input  logic                Sync,
`endif
  output logic [CHANNELS-1:0] Tick,
  output logic [CHANNELS-1:0] Clk_Div
);

  logic [CHANNELS-1:0] pend;
  logic [CHANNELS-1:0] wr_en;
  logic                div_rdy;

  // Selects at or beyond CHANNELS match no channel: not ready, write ignored.
  always_comb begin
    div_rdy = 1'b0;
    wr_en   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(div_if.Div_Sel) == i) begin
        div_rdy  = ~pend[i];
        wr_en[i] = div_if.Div_Wr & ~pend[i];
      end
    end
  end

  assign div_if.Div_Rdy = div_rdy;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    clk_div_chan #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_chan (
      .Clk     (Clk),
      .Rst_n   (Rst_n),
      .enable  (Enable[g]),
`ifdef CLKDIV_SYNC_EN
      .sync    (Sync),
`endif
      .wr_en   (wr_en[g]),
      .wr_data (div_if.Div_Data),
      .pend    (pend[g]),
      .tick    (Tick[g]),
      .clk_div (Clk_Div[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi; sync scenario runs only with CLKDIV_SYNC_EN.
module tb_clk_div_multi;

  logic       Clk;
  logic       Rst_n;
  logic [3:0] Enable;
  logic [3:0] Tick;
  logic [3:0] Clk_Div;
`ifdef CLKDIV_SYNC_EN
  logic       Sync;
`endif

  int n_checks;
  int n_pass;

  clk_div_multi_if #(.CHANNELS(4), .CNT_W(16)) bus ();

  clk_div_multi #(.CHANNELS(4), .CNT_W(16), .DEFAULT_HALF(4999)) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .Enable  (Enable),
    .div_if  (bus),
`ifdef CLKDIV_SYNC_EN
    .Sync    (Sync),
`endif
    .Tick    (Tick),
    .Clk_Div (Clk_Div)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic wr(input logic [1:0] sel, input logic [15:0] data);
    bus.Div_Wr   = 1'b1;
    bus.Div_Sel  = sel;
    bus.Div_Data = data;
    @(negedge Clk);
    bus.Div_Wr   = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (Tick !== 4'b0000) $display("FAIL reset_tick: got %b want 0000", Tick); else n_pass++;
    n_checks++; if (Clk_Div !== 4'b0000) $display("FAIL reset_clkdiv: got %b want 0000", Clk_Div); else n_pass++;
    n_checks++; if (bus.Div_Rdy !== 1'b1) $display("FAIL reset_rdy: got %b want 1", bus.Div_Rdy); else n_pass++;
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic et, ec;
    wr(2'd0, 16'd3);
    n_checks++; if (bus.Div_Rdy !== 1'b0) $display("FAIL basic_rdy_pend: got %b want 0", bus.Div_Rdy); else n_pass++;
    @(negedge Clk);
    n_checks++; if (bus.Div_Rdy !== 1'b1) $display("FAIL basic_rdy_applied: got %b want 1", bus.Div_Rdy); else n_pass++;
    Enable = 4'b0001;
    for (int k = 1; k <= 16; k++) begin
      @(negedge Clk);
      et = (k % 4 == 0);
      ec = ((k / 4) % 2 == 1);
      n_checks++; if (Tick[0] !== et) $display("FAIL basic_tick k=%0d: got %b want %b", k, Tick[0], et); else n_pass++;
      n_checks++; if (Clk_Div[0] !== ec) $display("FAIL basic_clkdiv k=%0d: got %b want %b", k, Clk_Div[0], ec); else n_pass++;
    end
  endtask

  // Edge numbering continues from test_basic (edge 16 was a terminal, cnt=0 after it).
  task automatic test_reload_and_drop();
    logic et, ec, er;
    @(negedge Clk);              // edge 17: cnt = 1
    bus.Div_Wr   = 1'b1;
    bus.Div_Sel  = 2'd0;
    bus.Div_Data = 16'd9;
    for (int m = 18; m <= 40; m++) begin
      @(negedge Clk);
      et = (m == 20 || m == 30 || m == 40);
      ec = (m >= 20 && m < 30) || (m >= 40);
      er = (m >= 20);
      n_checks++; if (Tick[0] !== et) $display("FAIL reload_tick m=%0d: got %b want %b", m, Tick[0], et); else n_pass++;
      n_checks++; if (Clk_Div[0] !== ec) $display("FAIL reload_clkdiv m=%0d: got %b want %b", m, Clk_Div[0], ec); else n_pass++;
      n_checks++; if (bus.Div_Rdy !== er) $display("FAIL reload_rdy m=%0d: got %b want %b", m, bus.Div_Rdy, er); else n_pass++;
      if (m == 18) bus.Div_Data = 16'd7;  // second write while pending: must be dropped
      if (m == 19) bus.Div_Wr = 1'b0;
    end
  endtask

  task automatic test_h_zero();
    logic ec;
    wr(2'd2, 16'd0);
    @(negedge Clk);
    Enable = 4'b0101;
    for (int k = 1; k <= 6; k++) begin
      @(negedge Clk);
      ec = (k % 2 == 1);
      n_checks++; if (Tick[2] !== 1'b1) $display("FAIL hzero_tick k=%0d: got %b want 1", k, Tick[2]); else n_pass++;
      n_checks++; if (Clk_Div[2] !== ec) $display("FAIL hzero_clkdiv k=%0d: got %b want %b", k, Clk_Div[2], ec); else n_pass++;
    end
  endtask

  task automatic test_disable();
    logic et;
    wr(2'd1, 16'd2);
    @(negedge Clk);
    Enable = 4'b0111;
    for (int k = 1; k <= 3; k++) begin
      @(negedge Clk);
      et = (k == 3);
      n_checks++; if (Tick[1] !== et) $display("FAIL dis_run_tick k=%0d: got %b want %b", k, Tick[1], et); else n_pass++;
    end
    n_checks++; if (Clk_Div[1] !== 1'b1) $display("FAIL dis_run_clkdiv: got %b want 1", Clk_Div[1]); else n_pass++;
    Enable = 4'b0101;
    @(negedge Clk);
    n_checks++; if (Tick[1] !== 1'b0) $display("FAIL dis_off_tick: got %b want 0", Tick[1]); else n_pass++;
    n_checks++; if (Clk_Div[1] !== 1'b0) $display("FAIL dis_off_clkdiv: got %b want 0", Clk_Div[1]); else n_pass++;
    wr(2'd1, 16'd5);
    n_checks++; if (bus.Div_Rdy !== 1'b0) $display("FAIL dis_rdy_pend: got %b want 0", bus.Div_Rdy); else n_pass++;
    @(negedge Clk);
    n_checks++; if (bus.Div_Rdy !== 1'b1) $display("FAIL dis_rdy_applied: got %b want 1", bus.Div_Rdy); else n_pass++;
    Enable = 4'b0111;
    for (int k = 1; k <= 6; k++) begin
      @(negedge Clk);
      et = (k == 6);
      n_checks++; if (Tick[1] !== et) $display("FAIL dis_reen_tick k=%0d: got %b want %b", k, Tick[1], et); else n_pass++;
      n_checks++; if (Clk_Div[1] !== et) $display("FAIL dis_reen_clkdiv k=%0d: got %b want %b", k, Clk_Div[1], et); else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    int early;
    early = 0;
    n_checks++; if (Tick[2] !== 1'b1) $display("FAIL arst_pre_tick2: got %b want 1", Tick[2]); else n_pass++;
    wr(2'd0, 16'd1);
    n_checks++; if (bus.Div_Rdy !== 1'b0) $display("FAIL arst_pre_rdy: got %b want 0", bus.Div_Rdy); else n_pass++;
    #2;
    Rst_n = 1'b0;
    #1;
    n_checks++; if (Tick !== 4'b0000) $display("FAIL arst_tick: got %b want 0000", Tick); else n_pass++;
    n_checks++; if (Clk_Div !== 4'b0000) $display("FAIL arst_clkdiv: got %b want 0000", Clk_Div); else n_pass++;
    n_checks++; if (bus.Div_Rdy !== 1'b1) $display("FAIL arst_rdy: got %b want 1", bus.Div_Rdy); else n_pass++;
    @(negedge Clk);
    Rst_n  = 1'b1;
    Enable = 4'b0001;
    for (int k = 1; k < 5000; k++) begin
      @(negedge Clk);
      if (Tick[0] !== 1'b0) early++;
    end
    n_checks++; if (early !== 0) $display("FAIL arst_early_ticks: got %0d want 0", early); else n_pass++;
    @(negedge Clk);
    n_checks++; if (Tick[0] !== 1'b1) $display("FAIL arst_default_tick: got %b want 1", Tick[0]); else n_pass++;
    n_checks++; if (Clk_Div[0] !== 1'b1) $display("FAIL arst_default_clkdiv: got %b want 1", Clk_Div[0]); else n_pass++;
  endtask

`ifdef CLKDIV_SYNC_EN
  task automatic test_sync();
    logic et, ec;
    Enable = 4'b0000;
    wr(2'd0, 16'd3);
    wr(2'd3, 16'd3);
    @(negedge Clk);
    Enable = 4'b0001;
    repeat (2) @(negedge Clk);
    Enable = 4'b1001;
    repeat (3) @(negedge Clk);
    Sync = 1'b1;
    @(negedge Clk);
    Sync = 1'b0;
    n_checks++; if (Tick !== 4'b0000) $display("FAIL sync_tick: got %b want 0000", Tick); else n_pass++;
    n_checks++; if (Clk_Div !== 4'b0000) $display("FAIL sync_clkdiv: got %b want 0000", Clk_Div); else n_pass++;
    for (int k = 1; k <= 8; k++) begin
      @(negedge Clk);
      et = (k % 4 == 0);
      ec = ((k / 4) % 2 == 1);
      n_checks++; if ({Tick[3], Tick[0]} !== {et, et}) $display("FAIL sync_tick k=%0d: got %b%b want %b%b", k, Tick[3], Tick[0], et, et); else n_pass++;
      n_checks++; if ({Clk_Div[3], Clk_Div[0]} !== {ec, ec}) $display("FAIL sync_clkdiv k=%0d: got %b%b want %b%b", k, Clk_Div[3], Clk_Div[0], ec, ec); else n_pass++;
    end
  endtask
`endif

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    Rst_n        = 1'b0;
    Enable       = 4'b0000;
    bus.Div_Wr   = 1'b0;
    bus.Div_Sel  = 2'd0;
    bus.Div_Data = 16'd0;
`ifdef CLKDIV_SYNC_EN
    Sync         = 1'b0;
`endif
    test_reset();
    test_basic();
    test_reload_and_drop();
    test_h_zero();
    test_disable();
    test_async_reset();
`ifdef CLKDIV_SYNC_EN
    test_sync();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
